seven_seg_scan_scheduler: RTL and testbench
===========================================

# seven_seg_scan_scheduler

Time-multiplexing scheduler for the 8-digit, active-low-anode seven-segment display on the Nexys board. It takes up to eight BCD nibbles from counters such as the up/down load counter. It sequences one digit at a time onto the shared segment decoder (BCD_to_sevenSeg) and drives the AN lines. Each digit slot begins with a short all-off guard interval to suppress ghosting. New data is applied only at frame boundaries so the display never tears.

## Interface
Parameters:
- SLOT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz); minimum 2.
- BLANK_CYCLES, 2000: guard cycles at start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < SLOT_CYCLES.

Ports:
- clock, input, 1: single system clock (CLK100MHZ domain).
- reset, input, 1: asynchronous, active-high reset.
- digits_in, input, 32: eight BCD nibbles; [3:0] is digit 0 (rightmost, AN[0]), [31:28] is digit 7.
- digit_enable, input, 8: per-digit enable; bit i=0 keeps digit i dark for its whole slot.
- update, input, 1: one-cycle strobe requesting that digits_in be shown from the next frame.
- AN, output, 8: anode drives, active low, at most one bit low at any time.
- BCD_out, output, 4: nibble for the currently scanned digit, to BCD_to_sevenSeg.
- digit_idx, output, 3: index of current slot.
- frame_done, output, 1: one-cycle pulse at end of slot 7.

## Operation
- Registers: slot counter cnt (0..SLOT_CYCLES-1), digit_idx (0..7), staging[31:0], shadow[31:0], pending flag, FSM state.
- FSM states:
  - GUARD: AN=8'hFF. Stays for cnt 0..BLANK_CYCLES-1. At cnt==BLANK_CYCLES-1 goes to DRIVE.
  - DRIVE: AN[digit_idx]=0 if digit_enable[digit_idx]=1, else AN=8'hFF. Stays until cnt==SLOT_CYCLES-1, then goes to GUARD with digit_idx+1 (7 wraps to 0) and cnt=0.
- Frame period is fixed: 8×SLOT_CYCLES, regardless of digit_enable. Disabled slots stay dark and are never skipped.
- BCD_out = shadow nibble [4·digit_idx+3 : 4·digit_idx] in both states, registered.
- digit_enable is sampled live on every cycle of DRIVE. Deasserting it mid-slot darkens that digit on the next edge.
- update handling:
  - update=1 loads staging<=digits_in and sets pending=1.
  - A later update before the frame boundary overwrites staging (last write wins).
- Frame boundary is the edge where cnt==SLOT_CYCLES-1 and digit_idx==7. On that edge:
  - frame_done=1 for exactly that cycle (registered, so visible the following cycle, coincident with digit_idx=0).
  - If pending, shadow<=staging and pending<=0.
  - If update is high in the boundary cycle, shadow<=digits_in directly (bypass) and pending stays 0.
- Reset (asynchronous, any time, including mid-slot): state=GUARD, cnt=0, digit_idx=0, AN=8'hFF, BCD_out=4'h0, frame_done=0, staging=0, shadow=0, pending=0. After reset release, first guard starts on the next edge.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Slot i occupies cycles [i·SLOT, (i+1)·SLOT) of the frame.
  - AN low only during cycles BLANK_CYCLES..SLOT_CYCLES-1 of the slot.
- AN transitions from one digit to the next always pass through ≥BLANK_CYCLES cycles of 8'hFF.
- BCD_out changes on the edge entering GUARD, never during DRIVE (unless at frame boundary with new shadow, which also enters GUARD).
- Latency from update to new value on BCD_out: 1 to 8×SLOT_CYCLES cycles, bounded by the next frame boundary.
- cnt width: $clog2(SLOT_CYCLES). Compare terminal values exactly, with no modular arithmetic beyond wrap to 0.

## Test plan
(Directed scenarios use SLOT_CYCLES=4, BLANK_CYCLES=1.)
- Reset then run 32 cycles, digit_enable=8'hFF, shadow=0:
  - AN sequence per slot is FF, FE, FE, FE, then FF, FD, FD, FD, … through 7F.
  - frame_done pulses once, at cycle 32.
- digit_enable=8'h01, update with digits_in=32'h0000_0009 before first boundary:
  - BCD_out=0 during frame 1, BCD_out=9 in slot 0 of frame 2.
  - AN=FE only in slot 0, FF elsewhere.
- Two updates in one frame (0x11111111 then 0x22222222):
  - Next frame shows all nibbles =2.
  - Value 1 is never displayed.
- update asserted exactly in boundary cycle with digits_in=32'h87654321:
  - Next frame slot k shows nibble k+1.
  - pending reads 0 afterward.
- Assert reset mid-DRIVE of slot 5:
  - AN=FF and digit_idx=0 immediately (asynchronously).
  - shadow cleared; after release, scan restarts from slot 0 GUARD.
- Toggle digit_enable[3] low during slot 3 DRIVE: AN returns to FF on the next edge; slot timing is unchanged.

Source files
------------

// File: rtl/seven_seg_scan_scheduler.sv
// Time-multiplexed scan of an 8-digit active-low-anode seven-segment display.
// Each slot opens with an all-dark guard interval; new digit data is latched only at frame boundaries.
module seven_seg_scan_scheduler #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_enable,
  input  logic        update,
  output logic [7:0]  AN,
  output logic [3:0]  BCD_out,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      staging_q, staging_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             frame_done_q, frame_done_d;
  logic             slot_end;
  logic             boundary;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= GUARD;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      staging_q    <= 32'h0;
      shadow_q     <= 32'h0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      bcd_q        <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    staging_d    = staging_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    an_d         = 8'hFF;
    slot_end     = (cnt_q == SLOT_LAST);
    boundary     = slot_end && (idx_q == 3'd7);
    frame_done_d = boundary;

    if (slot_end) begin
      cnt_d = '0;
    end

    case (state_q)
      GUARD: if (cnt_q == BLANK_LAST) state_d = DRIVE;
      DRIVE: begin
        if (slot_end) begin
          state_d = GUARD;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = GUARD;
    endcase

    // A strobe landing on the boundary itself bypasses staging so it is not delayed a whole frame.
    if (boundary) begin
      if (update) begin
        shadow_d  = digits_in;
        staging_d = digits_in;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
      pending_d = 1'b0;
    end else if (update) begin
      staging_d = digits_in;
      pending_d = 1'b1;
    end

    // Outputs are computed from next-state so they line up with the registered state.
    if (state_d == DRIVE && digit_enable[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
    bcd_d = shadow_d[{idx_d, 2'b00} +: 4];
  end

  assign AN         = an_q;
  assign BCD_out    = bcd_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_scheduler.sv
// Scoreboard bench for seven_seg_scan_scheduler: a time-based reference model predicts every
// cycle's outputs, pushes them into a queue, and an independent monitor pops and compares.
module tb_seven_seg_scan_scheduler;
  localparam int SLOT  = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits_in = 32'h0;
  logic [7:0]  digit_enable = 8'hFF;
  logic        update = 1'b0;
  logic [7:0]  AN;
  logic [3:0]  BCD_out;
  logic [2:0]  digit_idx;
  logic        frame_done;

  seven_seg_scan_scheduler #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clock(clock), .reset(reset), .digits_in(digits_in), .digit_enable(digit_enable),
    .update(update), .AN(AN), .BCD_out(BCD_out), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] an;
    logic [3:0] bcd;
    logic [2:0] idx;
    logic       fd;
    int         n;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: position in the frame follows from elapsed cycles alone.
  int          t;
  logic [31:0] shown, staged;
  bit          pend;

  task automatic cmp(input string name, input int n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, n, act, req);
    end
  endtask

  function automatic exp_t predict(input int n, input logic [7:0] en, input logic [31:0] disp);
    exp_t e;
    int slot, phase;
    slot  = (n / SLOT) % 8;
    phase = n % SLOT;
    e.an  = 8'hFF;
    if (phase >= BLANK && en[slot]) e.an[slot] = 1'b0;
    e.bcd = 4'((disp >> (4 * slot)) & 32'hF);
    e.idx = 3'(slot);
    e.fd  = (n > 0) && (n % FRAME == 0);
    e.n   = n;
    return e;
  endfunction

  // Caller is at a negedge: drive one cycle of inputs, predict the next cycle, advance.
  task automatic step(input logic [7:0] en, input logic upd, input logic [31:0] din);
    digit_enable = en;
    update       = upd;
    digits_in    = din;
    if (t % FRAME == FRAME - 1) begin
      if (upd) shown = din;
      else if (pend) shown = staged;
      pend = 1'b0;
    end else if (upd) begin
      staged = din;
      pend   = 1'b1;
    end
    sb_q.push_back(predict(t + 1, en, shown));
    t++;
    @(negedge clock);
  endtask

  task automatic run(input int cycles, input logic [7:0] en);
    for (int i = 0; i < cycles; i++) step(en, 1'b0, 32'h0);
  endtask

  task automatic run_until(input int frame_pos, input logic [7:0] en);
    for (int i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) step(en, 1'b0, 32'h0);
  endtask

  // Asserts reset mid-cycle, checks the outputs clear before any clock edge, releases at the next negedge.
  task automatic do_reset();
    exp_t e;
    #2 reset = 1'b1;
    update = 1'b0;
    #1;
    cmp("async_an", t, 32'(AN), 32'hFF);
    cmp("async_idx", t, 32'(digit_idx), 32'h0);
    cmp("async_bcd", t, 32'(BCD_out), 32'h0);
    cmp("async_fd", t, 32'(frame_done), 32'h0);
    e.an = 8'hFF; e.bcd = 4'h0; e.idx = 3'd0; e.fd = 1'b0; e.n = 0;
    sb_q.push_back(e);
    @(negedge clock);
    reset  = 1'b0;
    t      = 0;
    shown  = 32'h0;
    staged = 32'h0;
    pend   = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("AN", e.n, 32'(AN), 32'(e.an));
        cmp("BCD_out", e.n, 32'(BCD_out), 32'(e.bcd));
        cmp("digit_idx", e.n, 32'(digit_idx), 32'(e.idx));
        cmp("frame_done", e.n, 32'(frame_done), 32'(e.fd));
      end
    end
  end

  initial begin : stimulus
    t = 0; shown = 0; staged = 0; pend = 0;
    @(negedge clock);
    do_reset();

    // Plain scan with empty shadow: per-slot FF,FE,FE,FE ... and one frame_done at cycle 32.
    run(40, 8'hFF);

    // Only digit 0 lit; value 9 staged mid-frame appears from the next frame.
    step(8'h01, 1'b1, 32'h0000_0009);
    run(2 * FRAME, 8'h01);

    // Two updates in one frame: last write wins.
    run_until(3, 8'hFF);
    step(8'hFF, 1'b1, 32'h1111_1111);
    run(5, 8'hFF);
    step(8'hFF, 1'b1, 32'h2222_2222);
    run(FRAME + 4, 8'hFF);

    // Update exactly in the boundary cycle bypasses staging.
    run_until(FRAME - 1, 8'hFF);
    step(8'hFF, 1'b1, 32'h8765_4321);
    run(2 * FRAME, 8'hFF);

    // Drop digit 3 during its drive phase.
    run_until(3 * SLOT + 1, 8'hFF);
    step(8'hF7, 1'b0, 32'h0);
    step(8'hF7, 1'b0, 32'h0);
    run(FRAME, 8'hFF);

    // Reset in the middle of slot 5's drive phase, then verify restart from slot 0.
    step(8'hFF, 1'b1, 32'h9999_9999);
    run_until(5 * SLOT + 2, 8'hFF);
    do_reset();
    run(FRAME + 8, 8'hFF);

    // Randomized traffic with one extra reset in the middle.
    for (int i = 0; i < 800; i++) begin
      logic [7:0]  en;
      logic        upd;
      logic [31:0] din;
      en  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      upd = ($urandom_range(0, 19) == 0);
      din = $urandom;
      if ((t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 0) upd = 1'b1;
      step(en, upd, din);
      if (i == 400) do_reset();
    end
    run(4, 8'hFF);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
